// File: rtl/csi_rx_packet_sequencer.sv
// CSI-2 RX packet sequencer: arms combiner sync, parses packet
// headers, streams long-packet payload and ends each packet.
//
// Ports:
//   clock, reset        byte clock, synchronous active-high reset
//   enable              clock enable; everything holds when low
//   word_in/valid/frame word stream from the word combiner
//   wait_for_sync       to combiner: armed for next sync sequence
//   packet_done         to combiner: end current packet (pulse)
//   hdr_valid/dt/vc/wc  parsed header fields (valid is a pulse)
//   payload/_valid/_last long-packet payload words incl. CRC bytes
//   frame_start/end     short packet sync pulses (DT 0x00/0x01)
//   line_start/end      short packet sync pulses (DT 0x02/0x03)
//   error               oversize WC, frame drop or timeout pulse
module csi_rx_packet_sequencer #(
  parameter logic [15:0] MAX_WC  = 16'd8192,
  parameter int          TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  input  logic        word_frame,
  output logic        wait_for_sync,
  output logic        packet_done,
  output logic        hdr_valid,
  output logic [5:0]  hdr_dt,
  output logic [1:0]  hdr_vc,
  output logic [15:0] hdr_wc,
  output logic [31:0] payload,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    DONE
  } state_t;

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t         state;
  logic [16:0]    rem;
  logic [WDW-1:0] wd;

  // Header decode of the incoming word (ECC byte ignored)
  logic [5:0]  in_dt;
  logic [1:0]  in_vc;
  logic [15:0] in_wc;
  logic        in_long;
  logic        in_wc_ok;
  logic [16:0] in_rem;
  logic        hdr_take;

  always_comb begin
    in_dt    = word_in[5:0];
    in_vc    = word_in[7:6];
    in_wc    = word_in[23:8];
    in_long  = (in_dt >= 6'h10);
    in_wc_ok = (in_wc <= MAX_WC);
    // Words to receive: payload plus 2 CRC bytes, rounded up
    in_rem   = ({1'b0, in_wc} + 17'd5) >> 2;
    hdr_take = word_valid & word_frame;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rem           <= '0;
      wd            <= '0;
      wait_for_sync <= 1'b1;
      packet_done   <= 1'b0;
      hdr_valid     <= 1'b0;
      hdr_dt        <= '0;
      hdr_vc        <= '0;
      hdr_wc        <= '0;
      payload       <= '0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      line_start    <= 1'b0;
      line_end      <= 1'b0;
      error         <= 1'b0;
    end else if (enable) begin
      packet_done   <= 1'b0;
      hdr_valid     <= 1'b0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      line_start    <= 1'b0;
      line_end      <= 1'b0;
      error         <= 1'b0;

      unique case (state)
        IDLE: begin
          wait_for_sync <= 1'b1;
          if (hdr_take) begin
            wait_for_sync <= 1'b0;
            hdr_valid     <= 1'b1;
            hdr_dt        <= in_dt;
            hdr_vc        <= in_vc;
            hdr_wc        <= in_wc;
            if (!in_long) begin
              frame_start <= (in_dt == 6'h00);
              frame_end   <= (in_dt == 6'h01);
              line_start  <= (in_dt == 6'h02);
              line_end    <= (in_dt == 6'h03);
              state       <= DONE;
            end else if (in_wc_ok) begin
              rem   <= in_rem;
              wd    <= '0;
              state <= PAYLOAD;
            end else begin
              error <= 1'b1;
              state <= DONE;
            end
          end
        end

        PAYLOAD: begin
          // A valid word wins over a same-cycle frame drop
          if (word_valid) begin
            payload       <= word_in;
            payload_valid <= 1'b1;
            rem           <= rem - 17'd1;
            wd            <= '0;
            if (rem == 17'd1) begin
              payload_last <= 1'b1;
              state        <= DONE;
            end
          end else if (!word_frame) begin
            error <= 1'b1;
            state <= DONE;
          end else if (wd == WD_LAST) begin
            error <= 1'b1;
            state <= DONE;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        DONE: begin
          packet_done   <= 1'b1;
          wait_for_sync <= 1'b0;
          rem           <= '0;
          wd            <= '0;
          state         <= IDLE;
        end

        default: begin
          wait_for_sync <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csi_rx_packet_sequencer.sv
// Directed bench for csi_rx_packet_sequencer.
// Linear stimulus, immediate-assertion checks.
module tb_csi_rx_packet_sequencer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_frame;
  logic        wait_for_sync;
  logic        packet_done;
  logic        hdr_valid;
  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_wc;
  logic [31:0] payload;
  logic        payload_valid;
  logic        payload_last;
  logic        frame_start;
  logic        frame_end;
  logic        line_start;
  logic        line_end;
  logic        error;

  int tests;
  int failed;
  int k;
  int cnt;

  csi_rx_packet_sequencer #(
    .MAX_WC (16'd8192),
    .TIMEOUT(1024)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_frame   (word_frame),
    .wait_for_sync(wait_for_sync),
    .packet_done  (packet_done),
    .hdr_valid    (hdr_valid),
    .hdr_dt       (hdr_dt),
    .hdr_vc       (hdr_vc),
    .hdr_wc       (hdr_wc),
    .payload      (payload),
    .payload_valid(payload_valid),
    .payload_last (payload_last),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .line_start   (line_start),
    .line_end     (line_end),
    .error        (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pulses();
    return {23'd0, packet_done, hdr_valid,
            payload_valid, payload_last,
            frame_start, frame_end, line_start,
            line_end, error};
  endfunction

  initial begin
    tests      = 0;
    failed     = 0;
    reset      = 1'b1;
    enable     = 1'b1;
    word_in    = '0;
    word_valid = 1'b0;
    word_frame = 1'b0;

    // 1: reset
    step();
    step();
    check("rst_wfs", 32'(wait_for_sync), 32'd1);
    check("rst_pulses", pulses(), 32'd0);
    check("rst_wc", 32'(hdr_wc), 32'd0);
    check("rst_payload", payload, 32'd0);
    reset = 1'b0;
    step();

    // 2: frame start short packet
    word_in    = 32'h0000_0000;
    word_valid = 1'b1;
    word_frame = 1'b1;
    step();
    word_valid = 1'b0;
    word_frame = 1'b0;
    check("fs_hdr_valid", 32'(hdr_valid), 32'd1);
    check("fs_pulse", 32'(frame_start), 32'd1);
    check("fs_other", {frame_end, line_start, line_end, error},
          32'd0);
    check("fs_wfs_low", 32'(wait_for_sync), 32'd0);
    check("fs_no_done", 32'(packet_done), 32'd0);
    step();
    check("fs_done", 32'(packet_done), 32'd1);
    check("fs_pulse_end", 32'(frame_start | hdr_valid), 32'd0);
    check("fs_done_wfs", 32'(wait_for_sync), 32'd0);
    step();
    check("fs_idle_wfs", 32'(wait_for_sync), 32'd1);
    check("fs_done_end", 32'(packet_done), 32'd0);

    // Line end short packet, DT=0x03 VC=2
    word_in    = 32'h0000_0083;
    word_valid = 1'b1;
    word_frame = 1'b1;
    step();
    word_valid = 1'b0;
    word_frame = 1'b0;
    check("le_pulse", 32'(line_end), 32'd1);
    check("le_vc", 32'(hdr_vc), 32'd2);
    check("le_fs", 32'(frame_start | line_start), 32'd0);
    step();
    step();

    // 3: long packet DT=0x2B VC=1 WC=10 -> 3 words
    word_in    = 32'h5A00_0A6B;
    word_valid = 1'b1;
    word_frame = 1'b1;
    step();
    check("lp_hdr_valid", 32'(hdr_valid), 32'd1);
    check("lp_dt", 32'(hdr_dt), 32'h2B);
    check("lp_vc", 32'(hdr_vc), 32'd1);
    check("lp_wc", 32'(hdr_wc), 32'd10);
    word_in = 32'hA000_0001;
    step();
    check("lp_w1", payload, 32'hA000_0001);
    check("lp_w1_v", 32'(payload_valid), 32'd1);
    check("lp_w1_last", 32'(payload_last), 32'd0);
    word_valid = 1'b0;
    step();
    check("lp_gap_v", 32'(payload_valid), 32'd0);
    word_valid = 1'b1;
    word_in    = 32'hA000_0002;
    step();
    check("lp_w2", payload, 32'hA000_0002);
    check("lp_w2_last", 32'(payload_last), 32'd0);
    word_in = 32'hA000_0003;
    step();
    word_valid = 1'b0;
    word_frame = 1'b0;
    check("lp_w3", payload, 32'hA000_0003);
    check("lp_w3_last", 32'(payload_last), 32'd1);
    check("lp_w3_done", 32'(packet_done), 32'd0);
    step();
    check("lp_done", 32'(packet_done), 32'd1);
    check("lp_done_v", 32'(payload_valid), 32'd0);
    step();
    check("lp_idle_wfs", 32'(wait_for_sync), 32'd1);

    // 4: oversize WC=9000, FS word offered during DONE
    word_in    = 32'h0023_2812;
    word_valid = 1'b1;
    word_frame = 1'b1;
    step();
    check("ov_err", 32'(error), 32'd1);
    check("ov_wc", 32'(hdr_wc), 32'd9000);
    check("ov_no_v", 32'(payload_valid), 32'd0);
    word_in = 32'h0000_0000;
    step();
    word_valid = 1'b0;
    word_frame = 1'b0;
    check("ov_done", 32'(packet_done), 32'd1);
    check("ov_err_end", 32'(error), 32'd0);
    check("ov_ignored", 32'(frame_start | hdr_valid), 32'd0);
    step();
    check("ov_idle", pulses(), 32'd0);
    check("ov_wfs", 32'(wait_for_sync), 32'd1);

    // 5: WC=100 with frame drop after 5 words
    word_in    = 32'h0000_642A;
    word_valid = 1'b1;
    word_frame = 1'b1;
    step();
    check("fd_wc", 32'(hdr_wc), 32'd100);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      word_in = 32'hB000_0000 + 32'(i);
      step();
      if (payload_valid) cnt++;
      if (payload_last) cnt += 100;
    end
    check("fd_words", 32'(cnt), 32'd5);
    check("fd_last_w", payload, 32'hB000_0004);
    word_valid = 1'b0;
    word_frame = 1'b0;
    step();
    check("fd_err", 32'(error), 32'd1);
    check("fd_no_last", 32'(payload_last | payload_valid), 32'd0);
    step();
    check("fd_done", 32'(packet_done), 32'd1);
    step();
    word_in    = 32'h0000_0000;
    word_valid = 1'b1;
    word_frame = 1'b1;
    step();
    word_valid = 1'b0;
    word_frame = 1'b0;
    check("fd_next_fs", 32'(frame_start), 32'd1);
    check("fd_next_hv", 32'(hdr_valid), 32'd1);
    step();
    step();

    // 6: WC=8 stalls after one word until timeout
    word_in    = 32'h0000_082B;
    word_valid = 1'b1;
    word_frame = 1'b1;
    step();
    word_in = 32'hC000_0001;
    step();
    check("to_w1", 32'(payload_valid), 32'd1);
    word_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 1100 && !error; i++) begin
      step();
      k++;
    end
    check("to_cycles", 32'(k), 32'd1024);
    check("to_err", 32'(error), 32'd1);
    check("to_no_last", 32'(payload_last), 32'd0);
    word_frame = 1'b0;
    step();
    check("to_done", 32'(packet_done), 32'd1);

    // Freeze with enable low while a header is offered
    enable     = 1'b0;
    word_in    = 32'h0000_0000;
    word_valid = 1'b1;
    word_frame = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (packet_done !== 1'b1) cnt++;
      if (wait_for_sync !== 1'b0) cnt++;
      if (hdr_valid !== 1'b0) cnt++;
    end
    check("en_frozen", 32'(cnt), 32'd0);
    word_valid = 1'b0;
    word_frame = 1'b0;
    enable     = 1'b1;
    step();
    check("en_resume_done", 32'(packet_done), 32'd0);
    check("en_resume_wfs", 32'(wait_for_sync), 32'd1);

    // Reset mid-packet
    word_in    = 32'h0000_102A;
    word_valid = 1'b1;
    word_frame = 1'b1;
    step();
    word_in = 32'hD000_0001;
    step();
    reset = 1'b1;
    step();
    reset      = 1'b0;
    word_valid = 1'b0;
    word_frame = 1'b0;
    check("mr_wfs", 32'(wait_for_sync), 32'd1);
    check("mr_pulses", pulses(), 32'd0);
    step();
    check("mr_after", 32'(packet_done | payload_last), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
